seg_scan_ctrl: RTL

//   Time-multiplexes one BCD-to-seven-segment decode path across the four-digit

---
 rtl/seg_pkg.sv | 21 ++
 rtl/bcd_seg_dec.sv | 28 ++
 rtl/seg_scan_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and glyph constants for the four-digit seven-segment scan path.
// Segment encoding is {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;

endpackage

// File: rtl/bcd_seg_dec.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-BCD codes 10-15 decode to all segments off.
module bcd_seg_dec
    import seg_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    // Glyph lookup
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = GLYPH_0;
            4'd1:    seg = GLYPH_1;
            4'd2:    seg = GLYPH_2;
            4'd3:    seg = GLYPH_3;
            4'd4:    seg = GLYPH_4;
            4'd5:    seg = GLYPH_5;
            4'd6:    seg = GLYPH_6;
            4'd7:    seg = GLYPH_7;
            4'd8:    seg = GLYPH_8;
            4'd9:    seg = GLYPH_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller with guard cycle and tear-free frame update.
// Optional: define LEADING_ZERO_BLANK_EN to darken leading zeros in digits 3..1.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic        load,
    input  logic [3:0]  blank_mask,
    output logic        upd_pend,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] div_cnt_r;
    logic [1:0]       idx_r;
    logic [15:0]      shadow_r;
    logic [15:0]      disp_r;
    logic             upd_pend_r;
    logic [6:0]       seg_r;
    logic [3:0]       an_r;

    logic             tick_s;
    logic             boundary_s;
    bcd_t             digit_s;
    logic [6:0]       glyph_s;
    logic [3:0]       lz_s;
    logic             dark_s;

    assign tick_s     = (div_cnt_r == CNT_MAX);
    assign boundary_s = tick_s && (idx_r == 2'd3);

    // Select the digit of the committed frame for the active slot
    always_comb begin
        digit_s = 4'd0;
        case (idx_r)
            2'd0:    digit_s = disp_r[3:0];
            2'd1:    digit_s = disp_r[7:4];
            2'd2:    digit_s = disp_r[11:8];
            2'd3:    digit_s = disp_r[15:12];
            default: digit_s = 4'd0;
        endcase
    end

    bcd_seg_dec u_dec (
        .bcd (digit_s),
        .seg (glyph_s)
    );

    // Leading-zero suppression chain: a zero digit stays dark only while every higher digit is zero
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        lz_s    = 4'b0000;
        lz_s[3] = (disp_r[15:12] == 4'd0);
        lz_s[2] = lz_s[3] && (disp_r[11:8] == 4'd0);
        lz_s[1] = lz_s[2] && (disp_r[7:4] == 4'd0);
        lz_s[0] = 1'b0;
`else
        lz_s    = 4'b0000;
`endif
    end

    assign dark_s = blank_mask[idx_r] | lz_s[idx_r];

    // Divider, slot index, shadow/display frame registers and pending flag
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r  <= '0;
            idx_r      <= 2'd0;
            shadow_r   <= 16'h0000;
            disp_r     <= 16'h0000;
            upd_pend_r <= 1'b0;
        end else begin
            if (tick_s) begin
                div_cnt_r <= '0;
                idx_r     <= idx_r + 2'd1;
            end else begin
                div_cnt_r <= div_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // Old shadow commits before a coincident load overwrites it
            if (boundary_s && upd_pend_r) begin
                disp_r <= shadow_r;
            end
            if (load) begin
                shadow_r   <= digits_in;
                upd_pend_r <= 1'b1;
            end else if (boundary_s) begin
                upd_pend_r <= 1'b0;
            end
        end
    end

    // Registered pin drive; slot start is a guard cycle with all anodes off
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= 4'hF;
            seg_r <= SEG_BLANK;
        end else if (div_cnt_r == '0) begin
            an_r  <= 4'hF;
            seg_r <= SEG_BLANK;
        end else begin
            an_r  <= ~(4'b0001 << idx_r);
            seg_r <= dark_s ? SEG_BLANK : glyph_s;
        end
    end

    assign upd_pend = upd_pend_r;
    assign seg      = seg_r;
    assign an       = an_r;

endmodule
